// File: rtl/mul_pkg.sv
// Shared types and defaults for the shift-and-add multiplier.
package mul_pkg;

  localparam int MUL_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/addsub_rca.sv
// Combinational N-bit ripple-carry adder/subtractor; sub=1 computes a - b
// by inverting b and injecting a carry of 1 into the first cell.
module addsub_rca #(
  parameter int N = 9
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic [N-1:0] s
);

  logic [N-1:0] bx;
  logic [N-1:0] c;

  assign bx   = b ^ {N{sub}};
  assign c[0] = sub;

  // The carry out of the top cell is not needed: the caller sizes N so the
  // result never wraps.
  for (genvar i = 0; i < N; i++) begin : g_fa
    assign s[i] = a[i] ^ bx[i] ^ c[i];
    if (i < N - 1) begin : g_carry
      assign c[i+1] = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
    end
  end

endmodule

// File: rtl/shift_add_mul.sv
// Sequential W x W shift-and-add multiplier, one multiplier bit per cycle.
// Define SIGNED_MUL_EN to add the SGN port for two's-complement operands.
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_IDLE | waiting for START; operands latched on acceptance
// ST_CALC | cnt != 0: consume one multiplier bit; cnt == 0: write P
// ST_DONE | one-cycle DONE pulse with P valid
module shift_add_mul
  import mul_pkg::*;
#(
  parameter int W = MUL_W_DEFAULT
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           START,
  input  logic [W-1:0]   A,
  input  logic [W-1:0]   B,
`ifdef SIGNED_MUL_EN
  input  logic           SGN,
`endif
  output logic [2*W-1:0] P,
  output logic           BUSY,
  output logic           DONE
);

  localparam int CW = $clog2(W + 1);

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   cnt;
  logic [W:0]      acc_hi;
  logic [W-1:0]    acc_lo;
  logic [W-1:0]    a_reg;
  logic [W:0]      add_op;
  logic [W:0]      sum;
  logic            sgn_r;
  logic            sub_en;
  logic            fill;
  logic [2*W+1:0]  shift_src;

`ifdef SIGNED_MUL_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      sgn_r <= 1'b0;
    end else if (state == ST_IDLE && START) begin
      sgn_r <= SGN;
    end
  end

  // Multiplier MSB carries negative weight in two's complement.
  assign sub_en = sgn_r & acc_lo[0] & (cnt == CW'(1));
`else
  assign sgn_r  = 1'b0;
  assign sub_en = 1'b0;
`endif

  assign add_op = acc_lo[0] ? {sgn_r & a_reg[W-1], a_reg} : '0;

  addsub_rca #(.N(W + 1)) u_addsub (
    .a   (acc_hi),
    .b   (add_op),
    .sub (sub_en),
    .s   (sum)
  );

  assign fill      = sgn_r ? sum[W] : 1'b0;
  assign shift_src = {fill, sum, acc_lo};

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (START) state_nxt = ST_CALC;
      ST_CALC: if (cnt == '0) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    BUSY = (state != ST_IDLE);
    DONE = (state == ST_DONE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      a_reg  <= '0;
      P      <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (START) begin
            a_reg  <= A;
            acc_hi <= '0;
            acc_lo <= B;
            cnt    <= CW'(W);
          end
        end
        ST_CALC: begin
          if (cnt != '0) begin
            acc_hi <= shift_src[2*W+1:W+1];
            acc_lo <= shift_src[W:1];
            cnt    <= cnt - CW'(1);
          end else begin
            P <= {acc_hi[W-1:0], acc_lo};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_mul.sv
// Directed self-checking bench for shift_add_mul (W=8 and W=1 instances).
module tb_shift_add_mul;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [15:0] P;
  logic        BUSY;
  logic        DONE;
  logic        START1;
  logic [0:0]  A1;
  logic [0:0]  B1;
  logic [1:0]  P1;
  logic        BUSY1;
  logic        DONE1;
`ifdef SIGNED_MUL_EN
  logic        SGN;
  logic        SGN1;
`endif

  int          checks = 0;
  int          failures = 0;
  int          done_pulses = 0;
  int          p0;
  logic [15:0] last_p;

  always #5 CLK = ~CLK;

  always @(negedge CLK) if (DONE) done_pulses++;

  shift_add_mul #(.W(8)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .START (START),
    .A     (A),
    .B     (B),
`ifdef SIGNED_MUL_EN
    .SGN   (SGN),
`endif
    .P     (P),
    .BUSY  (BUSY),
    .DONE  (DONE)
  );

  shift_add_mul #(.W(1)) dut1 (
    .CLK   (CLK),
    .RST   (RST),
    .START (START1),
    .A     (A1),
    .B     (B1),
`ifdef SIGNED_MUL_EN
    .SGN   (SGN1),
`endif
    .P     (P1),
    .BUSY  (BUSY1),
    .DONE  (DONE1)
  );

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Start accepted at edge k: DONE must appear only after edge k+9.
  task automatic run_mul(input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] exp, input string tag);
    logic early_done;
    logic busy_drop;
    early_done = 1'b0;
    busy_drop  = 1'b0;
    START = 1'b1; A = a; B = b;
    tick;
    START = 1'b0; A = ~a; B = ~b;
    chk({tag, "_busy_start"}, BUSY, 1);
    for (int i = 0; i < 8; i++) begin
      tick;
      if (DONE) early_done = 1'b1;
      if (!BUSY) busy_drop = 1'b1;
      if (i == 3) chk({tag, "_p_hold_calc"}, P, last_p);
    end
    chk({tag, "_early_done"}, early_done, 0);
    chk({tag, "_busy_drop"}, busy_drop, 0);
    tick;
    chk({tag, "_done"}, DONE, 1);
    chk({tag, "_p"}, P, exp);
    tick;
    chk({tag, "_done_clr"}, DONE, 0);
    chk({tag, "_busy_clr"}, BUSY, 0);
    last_p = exp;
  endtask

  initial begin
    RST = 1'b1; START = 1'b0; A = '0; B = '0;
    START1 = 1'b0; A1 = '0; B1 = '0;
`ifdef SIGNED_MUL_EN
    SGN = 1'b0; SGN1 = 1'b0;
`endif
    tick;
    tick;
    chk("rst_p", P, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_p_w1", P1, 0);
    chk("rst_busy_w1", BUSY1, 0);
    RST = 1'b0;
    last_p = 16'h0000;

    run_mul(8'd13, 8'd11, 16'h008F, "m13x11");
    run_mul(8'd255, 8'd255, 16'hFE01, "m255x255");
    run_mul(8'd0, 8'd200, 16'h0000, "m0x200_b2b");

    // START re-asserted with other operands during CALC must be ignored.
    p0 = done_pulses;
    START = 1'b1; A = 8'd6; B = 8'd7;
    tick;
    START = 1'b0;
    tick;
    tick;
    START = 1'b1; A = 8'd1; B = 8'd1;
    tick;
    tick;
    tick;
    START = 1'b0;
    tick;
    tick;
    tick;
    chk("ign_no_done_yet", DONE, 0);
    tick;
    chk("ign_done", DONE, 1);
    chk("ign_p", P, 16'h002A);
    tick;
    chk("ign_busy_clr", BUSY, 0);
    chk("ign_one_pulse", done_pulses - p0, 1);
    last_p = 16'h002A;

    // Reset during the 4th CALC cycle aborts silently.
    START = 1'b1; A = 8'd9; B = 8'd9;
    tick;
    START = 1'b0;
    tick;
    tick;
    tick;
    RST = 1'b1;
    tick;
    RST = 1'b0;
    chk("abort_p", P, 0);
    chk("abort_busy", BUSY, 0);
    chk("abort_done", DONE, 0);
    p0 = done_pulses;
    for (int i = 0; i < 10; i++) tick;
    chk("abort_no_pulse", done_pulses - p0, 0);
    last_p = 16'h0000;
    run_mul(8'd3, 8'd4, 16'h000C, "m3x4");

    // Reset wins over a simultaneous START.
    RST = 1'b1; START = 1'b1; A = 8'd5; B = 8'd5;
    tick;
    RST = 1'b0; START = 1'b0;
    chk("rst_start_busy", BUSY, 0);
    tick;
    chk("rst_start_busy2", BUSY, 0);
    chk("rst_start_p", P, 0);
    last_p = 16'h0000;

    run_mul(8'd2, 8'd5, 16'h000A, "m2x5");
    for (int i = 0; i < 4; i++) tick;
    chk("idle_p_hold", P, 16'h000A);
    run_mul(8'd7, 8'd9, 16'h003F, "m7x9");

`ifdef SIGNED_MUL_EN
    SGN = 1'b1;
    run_mul(8'hFD, 8'h05, 16'hFFF1, "s_m3x5");
    run_mul(8'h80, 8'h80, 16'h4000, "s_m128xm128");
    SGN = 1'b0;
    run_mul(8'hFD, 8'h05, 16'h04F1, "u_253x5");
`endif

    // W=1: DONE two edges after acceptance.
    START1 = 1'b1; A1 = 1'b1; B1 = 1'b1;
    tick;
    START1 = 1'b0; A1 = 1'b0; B1 = 1'b0;
    chk("w1_busy", BUSY1, 1);
    chk("w1_done_early", DONE1, 0);
    tick;
    chk("w1_done_early2", DONE1, 0);
    tick;
    chk("w1_done", DONE1, 1);
    chk("w1_p", P1, 2'b01);
    tick;
    chk("w1_done_clr", DONE1, 0);
    chk("w1_busy_clr", BUSY1, 0);
    START1 = 1'b1; A1 = 1'b1; B1 = 1'b0;
    tick;
    START1 = 1'b0;
    tick;
    tick;
    chk("w1_done_b0", DONE1, 1);
    chk("w1_p_b0", P1, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
